// File: rtl/acc_pkg.sv
// Shared types and default widths for the signed accumulator.
package acc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_ADD  = 2'd2
  } state_t;

  localparam int IN_W_DEF  = 4;
  localparam int ACC_W_DEF = 8;

endpackage

// File: rtl/negate_word.sv
// Combinational two's-complement negation on W bits (wraps for the most negative value).
module negate_word #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = ~a + W'(1);

endmodule

// File: rtl/signed_accumulator.sv
// Signed add/subtract accumulator: IDLE latches an operand, PREP negates it for subtracts,
// ADD folds it into the wrapping running total and updates the sticky overflow flag.
module signed_accumulator
  import acc_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_sub,
  output logic signed [ACC_W-1:0] acc,
  output logic                    acc_valid,
  output logic                    ovf
);

  state_t                    r_state;
  state_t                    w_next;
  logic                      w_ready;
  logic                      w_xfer;
  logic signed [ACC_W-1:0]   w_ext;
  logic        [ACC_W-1:0]   w_neg;
  logic signed [ACC_W-1:0]   w_sum;
  logic signed [ACC_W-1:0]   r_op_p0;
  logic                      r_sub_p0;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_ovf;
  logic                      r_acc_vld;

  function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                   input logic signed [ACC_W-1:0] b,
                                   input logic signed [ACC_W-1:0] s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = !clear;
        if (in_valid && w_ready) w_next = S_PREP;
      end
      S_PREP:  w_next = S_ADD;
      S_ADD:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // clear abandons any in-flight operand
    if (clear) w_next = S_IDLE;
  end

  assign w_xfer = in_valid && w_ready;
  // Sign-extend before any negation so -2^(IN_W-1) negates without overflow.
  assign w_ext  = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign w_sum  = r_acc + r_op_p0;

  negate_word #(.W(ACC_W)) u_neg (
    .a (r_op_p0),
    .y (w_neg)
  );

  // ---- stage p0: operand capture (IDLE), then conditional negation (PREP)
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_op_p0  <= w_ext;
      r_sub_p0 <= in_sub;
    end else if (r_state == S_PREP && r_sub_p0) begin
      r_op_p0  <= w_neg;
    end
  end

  // ---- stage p1: accumulate (ADD)
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_acc_vld <= 1'b0;
    end else begin
      r_acc_vld <= 1'b0;
      if (r_state == S_ADD) begin
        r_acc     <= w_sum;
        r_ovf     <= r_ovf | add_ovf(r_acc, r_op_p0, w_sum);
        r_acc_vld <= 1'b1;
      end
    end
  end

  assign in_ready  = w_ready;
  assign acc       = r_acc;
  assign acc_valid = r_acc_vld;
  assign ovf       = r_ovf;

endmodule
